// File: rtl/sd_pkg.sv
// Shared definitions for the SD card subsystem.
//   OP_READ / OP_WRITE : operation codes presented to sd_card_controller
//   SECTOR_ADDR_W      : sector address width
//   SECTOR_BYTES       : bytes per SD sector
//   arb_state_t        : sd_request_arbiter sequencer states
package sd_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int unsigned SECTOR_ADDR_W = 26;
  localparam int unsigned SECTOR_BYTES  = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_TRANSFER,
    ST_DONE
  } arb_state_t;

endpackage

// File: rtl/sd_watchdog.sv
// Load/enable/expire cycle counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : restart the count from zero
//   en         : count this cycle
//   expire     : high during the enabled cycle that completes LIMIT counted cycles
module sd_watchdog #(
  parameter int unsigned LIMIT = 32'd4194304
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX_C  = W'(LIMIT);
  localparam logic [W-1:0] LAST_C = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != MAX_C)) begin
      count <= count + 1'b1;
    end
  end

  // Flag the last counted cycle combinationally so the owner can leave its
  // waiting state on exactly the LIMIT-th edge.
  assign expire = en && (count == LAST_C);

endmodule

// File: rtl/sd_request_arbiter.sv
// Two-port round-robin arbiter and sector sequencer in front of sd_card_controller.
//   clk, rst_n              : clock, synchronous active-low reset
//   req*/op*/sector*/wdata* : requester side inputs (port 0 and port 1)
//   gnt*/byte_stb*/done*/err*, rdata : requester side outputs
//   sd_op_code, sd_execute, sd_sector_address, sd_outgoing_byte : to the controller
//   sd_incoming_byte, sd_finished_byte, sd_finished_sector, sd_busy : from the controller
module sd_request_arbiter
  import sd_pkg::*;
#(
  parameter int unsigned BYTES_PER_SECTOR = SECTOR_BYTES,
  parameter int unsigned TIMEOUT_CYCLES   = 32'd4194304
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     op0,
  input  logic                     op1,
  input  logic [SECTOR_ADDR_W-1:0] sector0,
  input  logic [SECTOR_ADDR_W-1:0] sector1,
  input  logic [7:0]               wdata0,
  input  logic [7:0]               wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     byte_stb0,
  output logic                     byte_stb1,
  output logic                     done0,
  output logic                     done1,
  output logic                     err0,
  output logic                     err1,
  output logic [7:0]               rdata,
  output logic                     sd_op_code,
  output logic                     sd_execute,
  output logic [SECTOR_ADDR_W-1:0] sd_sector_address,
  output logic [7:0]               sd_outgoing_byte,
  input  logic [7:0]               sd_incoming_byte,
  input  logic                     sd_finished_byte,
  input  logic                     sd_finished_sector,
  input  logic                     sd_busy
);

  localparam int unsigned CW = $clog2(BYTES_PER_SECTOR + 1);
  localparam logic [CW-1:0] BPS_C = CW'(BYTES_PER_SECTOR);

  arb_state_t state, state_next;

  logic          last_grant;
  logic          owner;
  logic [CW-1:0] byte_cnt, cnt_next;
  logic          byte_over, over_next;
  logic          pick, pick_valid;
  logic          wd_load, wd_en, wd_expire;
  logic          err_next;
  logic          byte_hit;

  sd_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_load),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Round-robin pick: on a tie the port not granted last time wins.
  always_comb begin
    pick_valid = req0 || req1;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else begin
      pick = req1;
    end
  end

  // Byte accounting including a byte finishing in this very cycle, so a
  // same-cycle final byte and sector end compare the updated count.
  // The count saturates at the sector size; the overflow flag keeps the
  // excess visible as a mismatch.
  always_comb begin
    byte_hit  = (state == ST_TRANSFER) && sd_finished_byte;
    cnt_next  = byte_cnt;
    over_next = byte_over;
    if (byte_hit) begin
      if (byte_cnt == BPS_C) begin
        over_next = 1'b1;
      end else begin
        cnt_next = byte_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    wd_load    = 1'b0;
    wd_en      = 1'b0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!sd_busy && pick_valid) begin
          state_next = ST_ISSUE;
          wd_load    = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_ACCEPT;
      end
      ST_WAIT_ACCEPT: begin
        wd_en = 1'b1;
        if (wd_expire) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end else if (sd_busy) begin
          state_next = ST_TRANSFER;
        end
      end
      ST_TRANSFER: begin
        wd_en = 1'b1;
        if (sd_finished_sector) begin
          state_next = ST_DONE;
          err_next   = over_next || (cnt_next != BPS_C);
        end else if (wd_expire) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      last_grant        <= 1'b1;
      owner             <= 1'b0;
      byte_cnt          <= '0;
      byte_over         <= 1'b0;
      gnt0              <= 1'b0;
      gnt1              <= 1'b0;
      byte_stb0         <= 1'b0;
      byte_stb1         <= 1'b0;
      done0             <= 1'b0;
      done1             <= 1'b0;
      err0              <= 1'b0;
      err1              <= 1'b0;
      rdata             <= '0;
      sd_op_code        <= OP_READ;
      sd_execute        <= 1'b0;
      sd_sector_address <= '0;
    end else begin
      state      <= state_next;
      sd_execute <= (state == ST_ISSUE);
      byte_stb0  <= byte_hit && !owner;
      byte_stb1  <= byte_hit && owner;
      done0      <= (state_next == ST_DONE) && !owner;
      done1      <= (state_next == ST_DONE) && owner;
      err0       <= (state_next == ST_DONE) && !owner && err_next;
      err1       <= (state_next == ST_DONE) && owner && err_next;
      if (byte_hit) begin
        rdata <= sd_incoming_byte;
      end

      if ((state == ST_IDLE) && (state_next == ST_ISSUE)) begin
        owner             <= pick;
        gnt0              <= !pick;
        gnt1              <= pick;
        sd_op_code        <= pick ? op1 : op0;
        sd_sector_address <= pick ? sector1 : sector0;
        byte_cnt          <= '0;
        byte_over         <= 1'b0;
      end else begin
        byte_cnt  <= cnt_next;
        byte_over <= over_next;
      end

      if (state == ST_DONE) begin
        gnt0       <= 1'b0;
        gnt1       <= 1'b0;
        last_grant <= owner;
      end
    end
  end

  // Write data path is combinational from the owner's wdata; forced to zero
  // while nothing is granted so reset leaves every output low.
  always_comb begin
    sd_outgoing_byte = '0;
    if (gnt0 || gnt1) begin
      sd_outgoing_byte = owner ? wdata1 : wdata0;
    end
  end

endmodule
